// File: rtl/led_matrix_pwm_scan_pkg.sv
// Shared types and constants for the LED-matrix PWM row scanner.
package led_matrix_pwm_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_ACTIVE = 2'd3
    } scan_state_e;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_REFRESH_HZ = 60;

    // Idle column level for each polarity choice.
    localparam logic COL_OFF_LOW_ACTIVE  = 1'b1;
    localparam logic COL_OFF_HIGH_ACTIVE = 1'b0;

    function automatic logic col_off_level(input int active_low);
        return (active_low != 0) ? COL_OFF_LOW_ACTIVE : COL_OFF_HIGH_ACTIVE;
    endfunction

endpackage

// File: rtl/led_matrix_pwm_scan_fb_dbuf.sv
// Double-buffered pixel memory: host writes the back half, scanner
// reads one whole row of the front half per LOAD.
module led_fb_dbuf #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 12,
    parameter int RW   = 3,
    parameter int CW   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [RW-1:0]      wr_row_i,
    input  logic [CW-1:0]      wr_col_i,
    input  logic [DW-1:0]      wr_data_i,
    input  logic               rd_en_i,
    input  logic [RW-1:0]      rd_row_i,
    input  logic               toggle_i,
    output logic [COLS*DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2][ROWS][COLS];
    logic          sel_q;
    logic          wr_ok;

    assign wr_ok = wr_en_i
                 && (int'(wr_row_i) < ROWS)
                 && (int'(wr_col_i) < COLS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= 1'b0;
        end else if (toggle_i) begin
            sel_q <= ~sel_q;
        end
    end

    // Writes target the half that is back before any toggle this cycle.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[~sel_q][wr_row_i][wr_col_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            for (int c = 0; c < COLS; c++) begin
                rd_data_o[c*DW +: DW] <= mem_q[sel_q][rd_row_i][c];
            end
        end
    end

endmodule

// File: rtl/led_matrix_pwm_scan.sv
// RGB LED-matrix row scanner: blank/load/active row FSM with
// per-pixel PWM slots and frame-aligned front/back buffer swap.
module led_matrix_pwm_scan
    import led_matrix_pwm_scan_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int PWM_BITS       = 4,
    parameter int CLK_FREQ       = DEF_CLK_FREQ,
    parameter int REFRESH_HZ     = DEF_REFRESH_HZ,
    parameter int BLANK_CYC      = 16,
    parameter int COL_ACTIVE_LOW = 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  wr_en_i,
    input  logic [RW-1:0]         wr_row_i,
    input  logic [CW-1:0]         wr_col_i,
    input  logic [3*PWM_BITS-1:0] wr_rgb_i,
    input  logic                  swap_req_i,
    output logic                  swap_ack_o,
    output logic                  frame_start_o,
    output logic [ROWS-1:0]       row_o,
    output logic [COLS-1:0]       col_r_o,
    output logic [COLS-1:0]       col_g_o,
    output logic [COLS-1:0]       col_b_o
);

    localparam int DW       = 3 * PWM_BITS;
    localparam int NSLOT    = (2 ** PWM_BITS) - 1;
    localparam int ROW_CYC  = CLK_FREQ / (REFRESH_HZ * ROWS);
    localparam int SLOT_RAW = (ROW_CYC - BLANK_CYC - 1) / NSLOT;
    localparam int SLOT_CYC = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
    localparam int TMAX     = (BLANK_CYC > SLOT_CYC) ? BLANK_CYC : SLOT_CYC;
    localparam int TW       = $clog2(TMAX + 1);

    localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0]       SLOT_LAST  = TW'(SLOT_CYC - 1);
    localparam logic [PWM_BITS-1:0] SLOT_MAX   = PWM_BITS'(NSLOT - 1);
    localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);
    localparam logic [COLS-1:0]     COL_OFF    = {COLS{col_off_level(COL_ACTIVE_LOW)}};

    scan_state_e         state_q, state_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [PWM_BITS-1:0] slot_q, slot_d;
    logic [RW-1:0]       row_q, row_d;
    logic                pend_q, pend_d;
    logic                apply_swap;
    logic                rd_en;
    logic [COLS*DW-1:0]  rd_row;

    logic [ROWS-1:0] row_o_q, row_o_d;
    logic [COLS-1:0] col_r_q, col_g_q, col_b_q;
    logic [COLS-1:0] lit_r, lit_g, lit_b;
    logic            ack_q, frame_q, frame_d;

    led_fb_dbuf #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (DW),
        .RW   (RW),
        .CW   (CW)
    ) u_fb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_row_i  (wr_row_i),
        .wr_col_i  (wr_col_i),
        .wr_data_i (wr_rgb_i),
        .rd_en_i   (rd_en),
        .rd_row_i  (row_q),
        .toggle_i  (apply_swap),
        .rd_data_o (rd_row)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        row_d      = row_q;
        apply_swap = 1'b0;
        rd_en      = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            slot_d  = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    apply_swap = pend_q && (cnt_q == '0) && (row_q == '0);
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    rd_en   = 1'b1;
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
                ST_ACTIVE: begin
                    if (cnt_q != SLOT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (slot_q != SLOT_MAX) begin
                        cnt_d  = '0;
                        slot_d = slot_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        slot_d  = '0;
                        state_d = ST_BLANK;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A request arriving while a swap is being applied is absorbed by it.
    assign pend_d  = apply_swap ? 1'b0 : (pend_q | swap_req_i);
    assign frame_d = en_i && (state_q == ST_LOAD) && (row_q == '0);

    always_comb begin
        row_o_d = '0;
        lit_r   = '0;
        lit_g   = '0;
        lit_b   = '0;
        if (en_i && (state_q == ST_ACTIVE)) begin
            row_o_d = ROWS'(1) << row_q;
            for (int c = 0; c < COLS; c++) begin
                lit_r[c] = rd_row[c*DW + 2*PWM_BITS +: PWM_BITS] > slot_q;
                lit_g[c] = rd_row[c*DW + PWM_BITS +: PWM_BITS] > slot_q;
                lit_b[c] = rd_row[c*DW +: PWM_BITS] > slot_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            row_o_q <= '0;
            col_r_q <= COL_OFF;
            col_g_q <= COL_OFF;
            col_b_q <= COL_OFF;
            ack_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            row_o_q <= row_o_d;
            col_r_q <= lit_r ^ COL_OFF;
            col_g_q <= lit_g ^ COL_OFF;
            col_b_q <= lit_b ^ COL_OFF;
            ack_q   <= apply_swap;
            frame_q <= frame_d;
        end
    end

    assign row_o         = row_o_q;
    assign col_r_o       = col_r_q;
    assign col_g_o       = col_g_q;
    assign col_b_o       = col_b_q;
    assign swap_ack_o    = ack_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// Scoreboard bench for led_matrix_pwm_scan: a time-indexed frame model
// predicts every output cycle; a negedge monitor compares.
module tb_led_matrix_pwm_scan;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int BLANK  = 2;
    localparam int SLOT   = 7;
    localparam int PERIOD = 24;
    localparam int FRAME  = ROWS * PERIOD;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [2:0] wr_row_i = '0;
    logic [2:0] wr_col_i = '0;
    logic [5:0] wr_rgb_i = '0;
    logic       swap_req_i = 1'b0;
    logic       swap_ack_o, frame_start_o;
    logic [7:0] row_o, col_r_o, col_g_o, col_b_o;

    led_matrix_pwm_scan #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(2), .CLK_FREQ(1000),
        .REFRESH_HZ(5), .BLANK_CYC(BLANK), .COL_ACTIVE_LOW(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .wr_en_i(wr_en_i), .wr_row_i(wr_row_i), .wr_col_i(wr_col_i),
        .wr_rgb_i(wr_rgb_i), .swap_req_i(swap_req_i),
        .swap_ack_o(swap_ack_o), .frame_start_o(frame_start_o),
        .row_o(row_o), .col_r_o(col_r_o), .col_g_o(col_g_o), .col_b_o(col_b_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        logic [7:0] row, r, g, b;
        logic       ack, fs;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Model: two pixel planes, front select, pending flag, and the
    // cycle index j within the frame since scanning (re)started.
    int mem [2][ROWS][COLS];
    int shadow [COLS];
    int sel = 0, pend = 0, running = 0, j = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        sel = 0; pend = 0; running = 0; j = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int o, r, s;
        e.cyc = cyc + 1;
        e.row = 8'h00; e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
        e.ack = 1'b0;  e.fs = 1'b0;
        o = j % PERIOD;
        r = j / PERIOD;
        if (en_i && running != 0) begin
            if (o > BLANK) begin
                s = (o - BLANK - 1) / SLOT;
                e.row = 8'd1 << r;
                for (int c = 0; c < COLS; c++) begin
                    if (((shadow[c] >> 4) & 3) > s) e.r[c] = 1'b0;
                    if (((shadow[c] >> 2) & 3) > s) e.g[c] = 1'b0;
                    if ((shadow[c] & 3) > s)        e.b[c] = 1'b0;
                end
            end
            e.fs  = (o == BLANK) && (r == 0);
            e.ack = (j == 0) && (pend != 0);
        end
        sbq.push_back(e);
        if (en_i && running != 0 && o == BLANK)
            for (int c = 0; c < COLS; c++) shadow[c] = mem[sel][r][c];
        if (wr_en_i) mem[1-sel][wr_row_i][wr_col_i] = int'(wr_rgb_i);
        if (e.ack) begin
            sel = 1 - sel; pend = 0;
        end else if (swap_req_i) begin
            pend = 1;
        end
        if (!en_i) begin
            running = 0; j = 0;
        end else if (running == 0) begin
            running = 1; j = 0;
        end else begin
            j = (j + 1) % FRAME;
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                void'(sbq.pop_front());
                n_vec++; n_err++;
                $display("FAIL stale_entry cyc=%0d", cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk("row_o", row_o, e.row);
                chk("col_r_o", col_r_o, e.r);
                chk("col_g_o", col_g_o, e.g);
                chk("col_b_o", col_b_o, e.b);
                chk("swap_ack_o", {7'd0, swap_ack_o}, {7'd0, e.ack});
                chk("frame_start_o", {7'd0, frame_start_o}, {7'd0, e.fs});
            end
        end
    end

    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        swap_req_i = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input int rgb);
        wr_en_i = 1'b1;
        wr_row_i = 3'(r);
        wr_col_i = 3'(c);
        wr_rgb_i = 6'(rgb);
        step();
    endtask

    task automatic rnd_wr();
        if ($urandom_range(0, 2) == 0) begin
            wr_en_i = 1'b1;
            wr_row_i = 3'($urandom_range(0, 7));
            wr_col_i = 3'($urandom_range(0, 7));
            wr_rgb_i = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic fill_back();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr(r, c, int'($urandom_range(0, 63)));
    endtask

    task automatic run_until(input int target, input string nm);
        int k;
        k = 0;
        while (j != target && k < 2 * FRAME) begin
            rnd_wr(); step(); k++;
        end
        n_vec++;
        if (j != target) begin
            n_err++;
            $display("FAIL %s timeout got=%0d exp=%0d", nm, j, target);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_row", row_o, 8'h00);
        chk("reset_col_r", col_r_o, 8'hFF);
        chk("reset_ack", {7'd0, swap_ack_o}, 8'h00);
        rst_i = 1'b0;
        model_reset();

        fill_back();
        wr(3, 5, 6'b11_01_00);
        swap_req_i = 1'b1;
        step();
        repeat (5) step();
        en_i = 1'b1;
        for (int k = 0; k < 10 && sel == 0; k++) step();
        fill_back();

        for (int k = 0; k < 2 * FRAME; k++) begin
            rnd_wr();
            if (k >= FRAME && (j == 4 * PERIOD + 5 || j == 4 * PERIOD + 30))
                swap_req_i = 1'b1;
            step();
        end

        run_until(5 * PERIOD + 10, "wait_row5");
        en_i = 1'b0;
        swap_req_i = 1'b1;
        step();
        repeat (3) step();
        en_i = 1'b1;
        for (int k = 0; k < FRAME + 50; k++) begin
            rnd_wr(); step();
        end

        run_until(100, "wait_j100");
        swap_req_i = 1'b1;
        step();
        run_until(0, "wait_frame");
        wr(2, 2, 6'b10_11_01);
        for (int k = 0; k < FRAME; k++) begin
            rnd_wr(); step();
        end

        run_until(3 * PERIOD + 10, "wait_active");
        #5;
        rst_i = 1'b1;
        #1;
        chk("async_rst_row", row_o, 8'h00);
        chk("async_rst_col_r", col_r_o, 8'hFF);
        chk("async_rst_col_g", col_g_o, 8'hFF);
        chk("async_rst_col_b", col_b_o, 8'hFF);
        chk("async_rst_ack", {7'd0, swap_ack_o}, 8'h00);
        en_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        sbq.delete();
        rst_i = 1'b0;
        model_reset();
        repeat (6) step();
        en_i = 1'b1;
        for (int k = 0; k < FRAME + 30; k++) begin
            rnd_wr(); step();
        end
        en_i = 1'b0;
        repeat (2) step();
        @(posedge clk_i);
        #6;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
